// File: rtl/vga_timing_pkg.sv
// Shared widths, mode descriptor and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

  localparam int CNT_W     = 12;
  localparam int MAX_TOTAL = 1 << CNT_W;

  // One extra bit so a single region may span the full 4096-entry counter range.
  typedef logic [CNT_W:0] cnt_ext_t;

  typedef struct packed {
    cnt_ext_t active;
    cnt_ext_t fp;
    cnt_ext_t sync;
    cnt_ext_t bp;
  } vga_mode_t;

  localparam int VGA_640X480_DIV = 4;

  localparam vga_mode_t VGA_640X480_H = '{
    active: cnt_ext_t'(640),
    fp:     cnt_ext_t'(16),
    sync:   cnt_ext_t'(96),
    bp:     cnt_ext_t'(48)
  };

  localparam vga_mode_t VGA_640X480_V = '{
    active: cnt_ext_t'(480),
    fp:     cnt_ext_t'(10),
    sync:   cnt_ext_t'(2),
    bp:     cnt_ext_t'(33)
  };

  function automatic int mode_total(input vga_mode_t m);
    return int'(m.active) + int'(m.fp) + int'(m.sync) + int'(m.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter advanced by i_step, plus
// combinational region flags (sync, active, start) decoded from the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter vga_mode_t MODE = VGA_640X480_H
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sync,
  output logic             o_active,
  output logic             o_start
);

  localparam int       TOTAL   = mode_total(MODE);
  localparam cnt_ext_t LAST    = cnt_ext_t'(TOTAL - 1);
  localparam cnt_ext_t SYNC_LO = cnt_ext_t'(int'(MODE.active) + int'(MODE.fp));
  localparam cnt_ext_t SYNC_HI = cnt_ext_t'(int'(MODE.active) + int'(MODE.fp) + int'(MODE.sync));
  localparam cnt_ext_t ACT_LIM = MODE.active;

  logic [CNT_W-1:0] r_cnt;
  cnt_ext_t         w_cnt_ext;
  logic             w_last;

  assign w_cnt_ext = {1'b0, r_cnt};
  assign w_last    = (w_cnt_ext == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_step) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_wrap   = i_step && w_last;
  assign o_cnt    = r_cnt;
  assign o_sync   = (w_cnt_ext >= SYNC_LO) && (w_cnt_ext < SYNC_HI);
  assign o_active = (w_cnt_ext < ACT_LIM);
  assign o_start  = (r_cnt == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a programmable pixel clock-enable.
// Optional framebuffer look-ahead outputs (fetch_x/fetch_valid) under `VGA_TIMING_PREFETCH_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_640X480_DIV,
  parameter int H_ACTIVE = int'(VGA_640X480_H.active),
  parameter int H_FP     = int'(VGA_640X480_H.fp),
  parameter int H_SYNC   = int'(VGA_640X480_H.sync),
  parameter int H_BP     = int'(VGA_640X480_H.bp),
  parameter int V_ACTIVE = int'(VGA_640X480_V.active),
  parameter int V_FP     = int'(VGA_640X480_V.fp),
  parameter int V_SYNC   = int'(VGA_640X480_V.sync),
  parameter int V_BP     = int'(VGA_640X480_V.bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             CLK,
  input  logic             RESETN,
  output logic             pix_en,
  output logic             HS,
  output logic             VS,
  output logic             blank,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0] fetch_x,
  output logic             fetch_valid
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam vga_mode_t H_MODE = '{
    active: cnt_ext_t'(H_ACTIVE),
    fp:     cnt_ext_t'(H_FP),
    sync:   cnt_ext_t'(H_SYNC),
    bp:     cnt_ext_t'(H_BP)
  };

  localparam vga_mode_t V_MODE = '{
    active: cnt_ext_t'(V_ACTIVE),
    fp:     cnt_ext_t'(V_FP),
    sync:   cnt_ext_t'(V_SYNC),
    bp:     cnt_ext_t'(V_BP)
  };

  generate
    if (CLK_DIV < 1 || H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_cfg_error
      $error("vga_timing_gen: CLK_DIV must be >= 1 and H_TOTAL/V_TOTAL must fit 12-bit counters");
    end
  endgenerate

  // Stage p0: clock-enable divider; r_vld_p0 is the pix_en pulse.
  logic [DIV_W-1:0] r_div;
  logic             r_vld_p0;
  logic             w_div_wrap;

  assign w_div_wrap = (r_div == DIV_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_div    <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_div    <= w_div_wrap ? '0 : r_div + 1'b1;
      r_vld_p0 <= w_div_wrap;
    end
  end

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_wrap;
  logic             w_v_wrap_unused;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_h_start;
  logic             w_v_start;

  vga_axis_counter #(
    .MODE(H_MODE)
  ) u_hcnt (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_step  (r_vld_p0),
    .o_wrap  (w_h_wrap),
    .o_cnt   (w_hcnt),
    .o_sync  (w_h_sync),
    .o_active(w_h_act),
    .o_start (w_h_start)
  );

  // Frame end is implied by the (0,0) start decode, so the vertical wrap has no consumer.
  vga_axis_counter #(
    .MODE(V_MODE)
  ) u_vcnt (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_step  (w_h_wrap),
    .o_wrap  (w_v_wrap_unused),
    .o_cnt   (w_vcnt),
    .o_sync  (w_v_sync),
    .o_active(w_v_act),
    .o_start (w_v_start)
  );

  // Stage p1: outputs registered from the counter state present at the pix_en.
  logic             r_hs_p1;
  logic             r_vs_p1;
  logic             r_blank_p1;
  logic [CNT_W-1:0] r_x_p1;
  logic [CNT_W-1:0] r_y_p1;
  logic             r_ls_p1;
  logic             r_fs_p1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_hs_p1    <= ~HS_POL;
      r_vs_p1    <= ~VS_POL;
      r_blank_p1 <= 1'b1;
      r_x_p1     <= '0;
      r_y_p1     <= '0;
      r_ls_p1    <= 1'b0;
      r_fs_p1    <= 1'b0;
    end else if (r_vld_p0) begin
      r_hs_p1    <= w_h_sync ? HS_POL : ~HS_POL;
      r_vs_p1    <= w_v_sync ? VS_POL : ~VS_POL;
      r_blank_p1 <= ~(w_h_act & w_v_act);
      r_x_p1     <= w_h_act ? w_hcnt : '0;
      r_y_p1     <= w_vcnt;
      r_ls_p1    <= w_h_start;
      r_fs_p1    <= w_h_start & w_v_start;
    end
  end

  assign pix_en      = r_vld_p0;
  assign HS          = r_hs_p1;
  assign VS          = r_vs_p1;
  assign blank       = r_blank_p1;
  assign x           = r_x_p1;
  assign y           = r_y_p1;
  assign line_start  = r_ls_p1;
  assign frame_start = r_fs_p1;

`ifdef VGA_TIMING_PREFETCH_EN
  generate
    if (H_TOTAL < 2) begin : g_prefetch_cfg_error
      $error("vga_timing_gen: prefetch look-ahead needs H_TOTAL >= 2");
    end
  endgenerate

  // Look-ahead two pixels; crossing the line end moves to the next row of the frame.
  cnt_ext_t         w_h_ahead_raw;
  cnt_ext_t         w_h_ahead;
  logic             w_h_ahead_wrap;
  logic             w_v_last;
  logic [CNT_W-1:0] w_v_ahead;
  logic             w_fetch_valid;

  assign w_h_ahead_raw  = {1'b0, w_hcnt} + cnt_ext_t'(2);
  assign w_h_ahead_wrap = (w_h_ahead_raw >= cnt_ext_t'(H_TOTAL));
  assign w_h_ahead      = w_h_ahead_wrap ? w_h_ahead_raw - cnt_ext_t'(H_TOTAL) : w_h_ahead_raw;
  assign w_v_last       = ({1'b0, w_vcnt} == cnt_ext_t'(V_TOTAL - 1));
  assign w_v_ahead      = !w_h_ahead_wrap ? w_vcnt : (w_v_last ? '0 : w_vcnt + 1'b1);
  assign w_fetch_valid  = (w_h_ahead < cnt_ext_t'(H_ACTIVE)) &&
                          ({1'b0, w_v_ahead} < cnt_ext_t'(V_ACTIVE));

  logic [CNT_W-1:0] r_fetch_x_p1;
  logic             r_fetch_valid_p1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_fetch_x_p1     <= '0;
      r_fetch_valid_p1 <= 1'b0;
    end else if (r_vld_p0) begin
      r_fetch_x_p1     <= w_fetch_valid ? CNT_W'(w_h_ahead) : '0;
      r_fetch_valid_p1 <= w_fetch_valid;
    end
  end

  assign fetch_x     = r_fetch_x_p1;
  assign fetch_valid = r_fetch_valid_p1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three timing generators (default, CLK_DIV=1 positive-HS, small CLK_DIV=3)
// compared every clock against an arithmetic raster model, with randomly placed asynchronous resets.
module tb_vga_timing_gen;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  bit   clk_run = 1'b1;

  int t     = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 if (clk_run) CLK = ~CLK;

  logic d_pix_en, d_HS, d_VS, d_blank, d_ls, d_fs;
  logic [11:0] d_x, d_y;
  logic a_pix_en, a_HS, a_VS, a_blank, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic s_pix_en, s_HS, s_VS, s_blank, s_ls, s_fs;
  logic [11:0] s_x, s_y;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [11:0] d_fx, a_fx, s_fx;
  logic d_fv, a_fv, s_fv;
`endif

  vga_timing_gen u_def (
    .CLK(CLK), .RESETN(RESETN), .pix_en(d_pix_en), .HS(d_HS), .VS(d_VS), .blank(d_blank),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(d_fx), .fetch_valid(d_fv)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_alt (
    .CLK(CLK), .RESETN(RESETN), .pix_en(a_pix_en), .HS(a_HS), .VS(a_VS), .blank(a_blank),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(a_fx), .fetch_valid(a_fv)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_sml (
    .CLK(CLK), .RESETN(RESETN), .pix_en(s_pix_en), .HS(s_HS), .VS(s_VS), .blank(s_blank),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(s_fx), .fetch_valid(s_fv)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Expected {pix_en,HS,VS,blank,x,y,line_start,frame_start} after tt clock edges since reset release.
  function automatic logic [29:0] model(input int tt, input int cdiv,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input bit hpol, input bit vpol);
    int n, p, h, v, htot, vtot;
    logic pe, h_in, v_in, hs_on, vs_on;
    logic [11:0] xv, yv;
    pe = (tt >= cdiv) && (tt % cdiv == 0);
    n  = (tt > cdiv) ? (tt - 1) / cdiv : 0;
    if (n == 0) return {pe, ~hpol, ~vpol, 1'b1, 24'd0, 2'b00};
    htot  = ha + hf + hs + hb;
    vtot  = va + vf + vs + vb;
    p     = n - 1;
    h     = p % htot;
    v     = (p / htot) % vtot;
    h_in  = (h < ha);
    v_in  = (v < va);
    hs_on = (h >= ha + hf) && (h < ha + hf + hs);
    vs_on = (v >= va + vf) && (v < va + vf + vs);
    xv    = h_in ? 12'(h) : 12'd0;
    yv    = 12'(v);
    return {pe, hs_on ? hpol : ~hpol, vs_on ? vpol : ~vpol, ~(h_in & v_in), xv, yv,
            (h == 0), (h == 0) && (v == 0)};
  endfunction

`ifdef VGA_TIMING_PREFETCH_EN
  function automatic logic [12:0] fmodel(input int tt, input int cdiv, input int ha, input int htot,
                                         input int va, input int vtot);
    int n, q, h, v;
    logic ok;
    n = (tt > cdiv) ? (tt - 1) / cdiv : 0;
    if (n == 0) return 13'd0;
    q  = n - 1 + 2;
    h  = q % htot;
    v  = (q / htot) % vtot;
    ok = (h < ha) && (v < va);
    return {ok, ok ? 12'(h) : 12'd0};
  endfunction
`endif

  int   d_ls_t = -1, d_hs_fall = -1, a_fs_t = -1, a_ls_t = -1, s_fs_t = -1, s_act = 0;
  logic d_ls_q = 1'b0, d_hs_q = 1'b0, a_fs_q = 1'b0, a_ls_q = 1'b0, s_fs_q = 1'b0;

  task automatic clear_trackers();
    d_ls_t = -1; d_hs_fall = -1; a_fs_t = -1; a_ls_t = -1; s_fs_t = -1; s_act = 0;
    d_ls_q = 1'b0; d_hs_q = 1'b0; a_fs_q = 1'b0; a_ls_q = 1'b0; s_fs_q = 1'b0;
  endtask

  task automatic check_all();
    chk("def", {d_pix_en, d_HS, d_VS, d_blank, d_x, d_y, d_ls, d_fs},
        model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    chk("alt", {a_pix_en, a_HS, a_VS, a_blank, a_x, a_y, a_ls, a_fs},
        model(t, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0));
    chk("sml", {s_pix_en, s_HS, s_VS, s_blank, s_x, s_y, s_ls, s_fs},
        model(t, 3, 6, 1, 2, 3, 3, 2, 1, 2, 1'b0, 1'b1));
`ifdef VGA_TIMING_PREFETCH_EN
    chk("def_fetch", {d_fv, d_fx}, fmodel(t, 4, 640, 800, 480, 525));
    chk("alt_fetch", {a_fv, a_fx}, fmodel(t, 1, 8, 14, 4, 7));
    chk("sml_fetch", {s_fv, s_fx}, fmodel(t, 3, 6, 12, 3, 8));
`endif
    // Default mode: 800-pixel lines, HS low for 96 pixels starting 656 pixels into the line.
    if (d_ls && !d_ls_q) begin
      if (d_ls_t >= 0) chk("def_line_period", t - d_ls_t, 800 * 4);
      d_ls_t = t;
    end
    if (!d_HS && !d_hs_q) begin
      if (d_ls_t >= 0) chk("def_hs_start", t - d_ls_t, 656 * 4);
      d_hs_fall = t;
    end
    if (d_HS && d_hs_q && d_hs_fall >= 0) chk("def_hs_width", t - d_hs_fall, 96 * 4);
    // Alternate mode: 14-CLK lines, 98-CLK frames.
    if (a_ls && !a_ls_q) begin
      if (a_ls_t >= 0) chk("alt_line_period", t - a_ls_t, 14);
      a_ls_t = t;
    end
    if (a_fs && !a_fs_q) begin
      if (a_fs_t >= 0) chk("alt_frame_period", t - a_fs_t, 98);
      a_fs_t = t;
    end
    // Small mode: 288-CLK frames with 6x3 visible pixels of 3 CLK each.
    if (s_fs && !s_fs_q) begin
      if (s_fs_t >= 0) begin
        chk("sml_frame_period", t - s_fs_t, 288);
        chk("sml_active_clks", s_act, 54);
      end
      s_fs_t = t;
      s_act  = 0;
    end
    if (!s_blank) s_act++;
    d_ls_q = d_ls; d_hs_q = !d_HS; a_ls_q = a_ls; a_fs_q = a_fs; s_fs_q = s_fs;
  endtask

  task automatic run_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (RESETN) t++;
      @(negedge CLK);
      check_all();
    end
  endtask

  // Called just after a falling edge: stop the clock, pulse reset, check, then restart.
  task automatic async_reset();
    clk_run = 1'b0;
    #7;
    RESETN = 1'b0;
    #1;
    t = 0;
    clear_trackers();
    check_all();
    #11;
    RESETN = 1'b1;
    #1;
    check_all();
    #2;
    clk_run = 1'b1;
  endtask

  initial begin
    int seg_len;
    RESETN = 1'b0;
    run_clocks(3);
    RESETN = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      seg_len = (seg == 0) ? 7200 : int'($urandom_range(2500, 60));
      run_clocks(seg_len);
      async_reset();
    end
    run_clocks(400);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
